fp32_to_fpu_operand_conv: RTL and testbench

Upstream operand stage for the custom-format FPU adder. Custom format: [31] sign, [30:25] exponent, bias 31, [24:0] mantissa with implicit leading 1.
- Accepts pairs of IEEE-754 binary32 operands over a valid/ready handshake.
- Converts each operand to the custom format and classifies special values.
- Presents the converted pair, held stable, to the adder's op_A_in/op_B_in through a 2-stage backpressured pipeline.
- Keeps per-pair flags, sticky flags and an accepted-pair counter.

---
 rtl/fp32_to_fpu_operand_conv.sv | 153 +++++++++++++++
 tb/tb_fp32_to_fpu_operand_conv.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_fpu_operand_conv.sv
// rtl/fp32_to_fpu_operand_conv.sv - IEEE binary32 operand pair to custom FPU format, 2-stage backpressured pipeline
//
// Custom format: [31] sign, [30:25] exponent (bias 31, field 0 reserved for zero),
// [24:0] mantissa with implicit leading 1.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake for the IEEE pair in_a/in_b
//   out_valid/out_ready    output handshake for the converted pair op_a/op_b
//   flags_a/flags_b        per-operand class: [3] invalid, [2] overflow, [1] underflow, [0] zero
//   sticky_flags           OR of flags of every pair transferred out; clear_sticky zeroes it
//   pair_count             pairs accepted at the input, wraps modulo 2^CNT_W

module fp32_to_fpu_operand_conv #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [3:0]       flags_a,
    output logic [3:0]       flags_b,
    output logic [3:0]       sticky_flags,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] pair_count
);

    // Returns {flags[3:0], custom[31:0]} for one IEEE operand.
    function automatic logic [35:0] conv(input logic [31:0] x);
        logic              s;
        logic [7:0]        e;
        logic [22:0]       m;
        logic signed [9:0] e_adj;
        s     = x[31];
        e     = x[30:23];
        m     = x[22:0];
        // Rebias in signed 10-bit so out-of-range exponents never alias into the 6-bit field.
        e_adj = $signed({2'b00, e}) - 10'sd96;
        if (e == 8'hFF)
            conv = {4'b1000, s, 6'h3F, 25'h1FF_FFFF};
        else if (e == 8'h00)
            conv = {((m == 23'd0) ? 4'b0001 : 4'b0011), s, 31'd0};
        else if (e_adj <= 10'sd0)
            conv = {4'b0011, s, 31'd0};
        else if (e_adj >= 10'sd64)
            conv = {4'b0100, s, 6'h3F, 25'h1FF_FFFF};
        else
            conv = {4'b0000, s, e_adj[5:0], m, 2'b00};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [31:0]      s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_op_a_q, s2_op_a_d;
    logic [31:0]      s2_op_b_q, s2_op_b_d;
    logic [3:0]       s2_flags_a_q, s2_flags_a_d;
    logic [3:0]       s2_flags_b_q, s2_flags_b_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        s2_adv, s1_adv, in_xfer, out_xfer;
    logic [35:0] conv_a, conv_b;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_xfer  = in_valid && s1_adv;
        out_xfer = s2_valid_q && out_ready;
        conv_a   = conv(s1_a_q);
        conv_b   = conv(s1_b_q);

        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s2_valid_d   = s2_valid_q;
        s2_op_a_d    = s2_op_a_q;
        s2_op_b_d    = s2_op_b_q;
        s2_flags_a_d = s2_flags_a_q;
        s2_flags_b_d = s2_flags_b_q;
        sticky_d     = sticky_q;
        count_d      = count_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d = in_a;
                s1_b_d = in_b;
            end
        end

        // S2 data only reloads when a real pair moves in, so outputs never glitch on bubbles.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_op_a_d    = conv_a[31:0];
                s2_flags_a_d = conv_a[35:32];
                s2_op_b_d    = conv_b[31:0];
                s2_flags_b_d = conv_b[35:32];
            end
        end

        if (clear_sticky)
            sticky_d = 4'd0;
        else if (out_xfer)
            sticky_d = sticky_q | s2_flags_a_q | s2_flags_b_q;

        if (in_xfer)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= 32'd0;
            s1_b_q       <= 32'd0;
            s2_valid_q   <= 1'b0;
            s2_op_a_q    <= 32'd0;
            s2_op_b_q    <= 32'd0;
            s2_flags_a_q <= 4'd0;
            s2_flags_b_q <= 4'd0;
            sticky_q     <= 4'd0;
            count_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s2_valid_q   <= s2_valid_d;
            s2_op_a_q    <= s2_op_a_d;
            s2_op_b_q    <= s2_op_b_d;
            s2_flags_a_q <= s2_flags_a_d;
            s2_flags_b_q <= s2_flags_b_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign in_ready     = s1_adv;
    assign out_valid    = s2_valid_q;
    assign op_a         = s2_op_a_q;
    assign op_b         = s2_op_b_q;
    assign flags_a      = s2_flags_a_q;
    assign flags_b      = s2_flags_b_q;
    assign sticky_flags = sticky_q;
    assign pair_count   = count_q;

endmodule

// File: tb/tb_fp32_to_fpu_operand_conv.sv
// tb/tb_fp32_to_fpu_operand_conv.sv - self-checking bench for fp32_to_fpu_operand_conv
module tb_fp32_to_fpu_operand_conv;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] op_a, op_b;
    logic [3:0]  flags_a, flags_b, sticky_flags;
    logic        clear_sticky = 1'b0;
    logic [15:0] pair_count;

    int n_checks = 0;
    int n_fail   = 0;

    fp32_to_fpu_operand_conv #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .flags_a(flags_a), .flags_b(flags_b), .sticky_flags(sticky_flags),
        .clear_sticky(clear_sticky), .pair_count(pair_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion from the format rules, using plain integer arithmetic.
    function automatic logic [35:0] ref_conv(input logic [31:0] x);
        int          e, m;
        logic [31:0] sgn;
        e   = int'(x[30:23]);
        m   = int'(x[22:0]);
        sgn = {x[31], 31'd0};
        if (e == 255) return {4'd8, sgn | 32'h7FFF_FFFF};
        if (e == 0)   return {((m == 0) ? 4'd1 : 4'd3), sgn};
        if (e < 97)   return {4'd3, sgn};
        if (e > 159)  return {4'd4, sgn | 32'h7FFF_FFFF};
        return {4'd0, sgn + 32'((e - 96) * (1 << 25) + m * 4)};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic [7:0]  e;
        logic [22:0] m;
        k = $urandom_range(0, 9);
        case (k)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(1, 96));
            3:       e = 8'd96;
            4:       e = 8'd97;
            5:       e = 8'd159;
            6:       e = 8'd160;
            7:       e = 8'($urandom_range(160, 254));
            default: e = 8'($urandom_range(97, 159));
        endcase
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Called #1 after a rising edge; returns at the falling edge where out_valid is seen.
    task automatic send_wait(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) begin ok = 1; break; end
            @(posedge clock); #1;
        end
        chk("out_valid_timeout", 32'(ok), 32'd1);
    endtask

    logic [31:0] p5a [4];
    logic [31:0] p5b [4];
    logic [71:0] q [$];
    logic [71:0] ent;
    logic [35:0] ra, rb;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_sticky, merged;
    int          idx, got;

    initial begin
        // Reset state
        @(posedge clock); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_flags", {flags_a, flags_b}, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_count", pair_count, 0);
        reset = 1'b1;

        // 1: latency and normal conversion
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4020_0000; out_ready = 1'b1;
        @(negedge clock);
        chk("s1_in_ready", in_ready, 1);
        @(posedge clock); #1; in_valid = 1'b0;
        @(negedge clock);
        chk("s1_latency_early", out_valid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("s1_out_valid", out_valid, 1);
        chk("s1_op_a", op_a, 32'h3E00_0000);
        chk("s1_op_b", op_b, 32'h4080_0000);
        chk("s1_flags", {flags_a, flags_b}, 0);
        chk("s1_count", pair_count, 1);

        // 2: negative normal and signed zero
        @(posedge clock); #1;
        send_wait(32'hBF80_0000, 32'h8000_0000);
        chk("s2_op_a", op_a, 32'hBE00_0000);
        chk("s2_op_b", op_b, 32'h8000_0000);
        chk("s2_flags_a", flags_a, 4'b0000);
        chk("s2_flags_b", flags_b, 4'b0001);
        @(posedge clock); #1;
        chk("s2_sticky", sticky_flags, 4'b0001);
        clear_sticky = 1'b1;
        @(posedge clock); #1;
        clear_sticky = 1'b0;
        chk("s2_sticky_clr", sticky_flags, 0);

        // 3: overflow boundary and NaN
        send_wait(32'h5000_0000, 32'h7FC0_0000);
        chk("s3_op_a", op_a, 32'h7FFF_FFFF);
        chk("s3_flags_a", flags_a, 4'b0100);
        chk("s3_op_b", op_b, 32'h7FFF_FFFF);
        chk("s3_flags_b", flags_b, 4'b1000);
        @(posedge clock); #1;
        chk("s3_sticky", sticky_flags, 4'b1100);

        // 4: underflow boundary and denormal
        send_wait(32'h3000_0000, 32'h0000_0001);
        chk("s4_op_a", op_a, 0);
        chk("s4_op_b", op_b, 0);
        chk("s4_flags_a", flags_a, 4'b0011);
        chk("s4_flags_b", flags_b, 4'b0011);
        @(posedge clock); #1;
        chk("s4_sticky", sticky_flags, 4'b1111);
        clear_sticky = 1'b1;
        @(posedge clock); #1;
        clear_sticky = 1'b0;
        chk("s4_sticky_clr", sticky_flags, 0);

        // clear_sticky in the same cycle as a flagged transfer wins
        send_wait(32'h7F80_0000, 32'h3F80_0000);
        clear_sticky = 1'b1;
        @(posedge clock); #1;
        clear_sticky = 1'b0;
        chk("clear_wins", sticky_flags, 0);

        // 5: backpressure with four back-to-back pairs
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        p5a[0] = 32'h3F80_0000; p5b[0] = 32'h4000_0000;
        p5a[1] = 32'h4040_0000; p5b[1] = 32'hC080_0000;
        p5a[2] = 32'h4F7F_FFFF; p5b[2] = 32'h3080_0000;
        p5a[3] = 32'h3FC0_0000; p5b[3] = 32'hBE80_0000;
        out_ready = 1'b0; idx = 0;
        ra = ref_conv(p5a[0]);
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1; in_a = p5a[idx]; in_b = p5b[idx];
            @(negedge clock);
            chk("s5_in_ready", in_ready, 32'(c < 2));
            if (in_ready && idx < 3) idx++;
            if (c >= 2) begin
                chk("s5_hold_valid", out_valid, 1);
                chk("s5_hold_op_a", op_a, ra[31:0]);
                chk("s5_hold_flags", flags_a, ra[35:32]);
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4); in_a = p5a[idx & 3]; in_b = p5b[idx & 3];
            @(negedge clock);
            if (out_valid) begin
                ra = ref_conv(p5a[got]);
                rb = ref_conv(p5b[got]);
                chk("s5_order_op_a", op_a, ra[31:0]);
                chk("s5_order_op_b", op_b, rb[31:0]);
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("s5_got", 32'(got), 4);
        chk("s5_count", pair_count, 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("s5_no_dup", out_valid, 0);
            @(posedge clock); #1;
        end

        // 6: reset while S1 and S2 are full
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h7FC0_0000; in_b = 32'h3F80_0000;
        @(posedge clock); #1;
        in_a = 32'h4020_0000; in_b = 32'h0000_0005;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("s6_full_valid", out_valid, 1);
        chk("s6_full_ready", in_ready, 0);
        #1 reset = 1'b0;
        #1;
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_ops", op_a | op_b, 0);
        chk("s6_rst_flags", {flags_a, flags_b, sticky_flags}, 0);
        chk("s6_rst_count", pair_count, 0);
        @(posedge clock); #1;
        reset = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("s6_no_stale", out_valid, 0);
            @(posedge clock); #1;
        end
        send_wait(32'h4020_0000, 32'hC020_0000);
        chk("s6_op_a", op_a, 32'h4080_0000);
        chk("s6_op_b", op_b, 32'hC080_0000);
        chk("s6_flags", {flags_a, flags_b}, 0);
        chk("s6_count", pair_count, 1);

        // Randomized traffic against the reference model and a scoreboard
        exp_cnt = 16'd1; exp_sticky = 4'd0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_a = rand_fp(); in_b = rand_fp();
            out_ready = ($urandom_range(0, 3) != 0);
            clear_sticky = ($urandom_range(0, 15) == 0);
            @(negedge clock);
            chk("rnd_sticky", sticky_flags, exp_sticky);
            chk("rnd_count", pair_count, exp_cnt);
            if (in_valid && in_ready) begin
                q.push_back({ref_conv(in_a), ref_conv(in_b)});
                exp_cnt++;
            end
            merged = 4'd0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    ent = q.pop_front();
                    chk("rnd_op_a", op_a, ent[67:36]);
                    chk("rnd_flags_a", flags_a, ent[71:68]);
                    chk("rnd_op_b", op_b, ent[31:0]);
                    chk("rnd_flags_b", flags_b, ent[35:32]);
                    merged = ent[71:68] | ent[35:32];
                end
            end
            if (clear_sticky) exp_sticky = 4'd0;
            else exp_sticky = exp_sticky | merged;
        end
        in_valid = 1'b0; clear_sticky = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (out_valid && q.size() > 0) begin
                ent = q.pop_front();
                chk("drain_op_a", op_a, ent[67:36]);
                chk("drain_op_b", op_b, ent[31:0]);
            end
            @(posedge clock); #1;
        end
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
